// File: rtl/stopwatch_game_pkg.sv
// Shared types and widths for the stop-at-zero game sequencer.
//   game_state_t : round phases IDLE -> RUN -> JUDGE -> RESULT
//   VAL_X10MS_W  : width of the stopwatch hundredths value
//   SCORE_W      : width of the saturating score
//   ATTEMPTS_W   : width of the saturating attempt counter
package stopwatch_game_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_JUDGE, ST_RESULT} game_state_t;

  localparam int VAL_X10MS_W = 7;
  localparam int SCORE_W     = 4;
  localparam int ATTEMPTS_W  = 7;

endpackage

// File: rtl/stopwatch_game_ctrl.sv
// Round sequencer for the stop-at-zero game. Drives the stopwatch run/clear
// inputs from the debounced go/clear pulses, judges each stop against x.00 and
// keeps a saturating score and attempt count.
// Ports:
//   clk_i        clock
//   res_ni       asynchronous reset, active-low
//   btn_go_i     one-cycle pulse: start / stop / next round
//   btn_clr_i    one-cycle pulse: abort round, zero score and attempts
//   val_x10ms_i  stopwatch hundredths value, 0..99
//   sw_en_o      stopwatch run enable
//   sw_clr_o     stopwatch clear, one-cycle pulse
//   win_o/lose_o round outcome, held while showing the result
//   score_o      wins, saturating at SCORE_MAX
//   attempts_o   judged rounds, saturating at 127
// Build option: STOPWATCH_GAME_AUTOCLR_EN adds a timeout that leaves RESULT
// after RESULT_TICKS cycles with a stopwatch clear pulse.
module stopwatch_game_ctrl
  import stopwatch_game_pkg::*;
#(
  parameter int WIN_TOL      = 2,
  parameter int SCORE_MAX    = 9,
  parameter int RESULT_TICKS = 100_000_000
) (
  input  logic                   clk_i,
  input  logic                   res_ni,
  input  logic                   btn_go_i,
  input  logic                   btn_clr_i,
  input  logic [VAL_X10MS_W-1:0] val_x10ms_i,
  output logic                   sw_en_o,
  output logic                   sw_clr_o,
  output logic                   win_o,
  output logic                   lose_o,
  output logic [SCORE_W-1:0]     score_o,
  output logic [ATTEMPTS_W-1:0]  attempts_o
);

  // 8-bit thresholds so 100-WIN_TOL cannot wrap in the value width.
  localparam logic [7:0] LO_THR = 8'(WIN_TOL);
  localparam logic [7:0] HI_THR = 8'(100 - WIN_TOL);

  game_state_t           state_q, state_d;
  logic                  sw_en_d, sw_clr_d, win_d, lose_d;
  logic [SCORE_W-1:0]    score_d;
  logic [ATTEMPTS_W-1:0] att_d;
  logic [7:0]            v8;
  logic                  is_win;
  logic                  auto_exit;

  assign v8 = {1'b0, val_x10ms_i};
  // Out-of-range values (>99) fall outside both windows and count as a loss.
  assign is_win = (v8 <= LO_THR) || ((v8 >= HI_THR) && (v8 <= 8'd99));

`ifdef STOPWATCH_GAME_AUTOCLR_EN
  localparam int CNT_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS + 1) : 1;
  logic [CNT_W-1:0] cnt_q;

  assign auto_exit = (state_q == ST_RESULT) && (cnt_q == CNT_W'(RESULT_TICKS - 1));

  // Counts cycles spent in RESULT; zero on entry and in every other state.
  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni)                                         cnt_q <= '0;
    else if (state_q == ST_RESULT && state_d == ST_RESULT) cnt_q <= cnt_q + 1'b1;
    else                                                 cnt_q <= '0;
  end
`else
  // Keeps the timeout parameter referenced when the timeout is not built.
  logic unused_ticks;
  assign unused_ticks = |RESULT_TICKS;
  assign auto_exit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sw_en_d  = sw_en_o;
    sw_clr_d = 1'b0;
    win_d    = win_o;
    lose_d   = lose_o;
    score_d  = score_o;
    att_d    = attempts_o;
    if (btn_clr_i) begin
      // Clear beats a simultaneous go press.
      state_d  = ST_IDLE;
      sw_en_d  = 1'b0;
      sw_clr_d = 1'b1;
      win_d    = 1'b0;
      lose_d   = 1'b0;
      score_d  = '0;
      att_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sw_en_d = 1'b0;
          if (btn_go_i) begin
            state_d = ST_RUN;
            sw_en_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (btn_go_i) begin
            state_d = ST_JUDGE;
            sw_en_d = 1'b0;
          end
        end
        ST_JUDGE: begin
          // Stopwatch has been frozen for a cycle; go presses are ignored here.
          state_d = ST_RESULT;
          win_d   = is_win;
          lose_d  = !is_win;
          if (is_win && (score_o < SCORE_W'(SCORE_MAX))) score_d = score_o + 1'b1;
          if (attempts_o != '1)                          att_d   = attempts_o + 1'b1;
        end
        ST_RESULT: begin
          if (btn_go_i || auto_exit) begin
            state_d  = ST_IDLE;
            sw_clr_d = 1'b1;
            win_d    = 1'b0;
            lose_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge res_ni) begin
    if (!res_ni) begin
      state_q    <= ST_IDLE;
      sw_en_o    <= 1'b0;
      sw_clr_o   <= 1'b0;
      win_o      <= 1'b0;
      lose_o     <= 1'b0;
      score_o    <= '0;
      attempts_o <= '0;
    end else begin
      state_q    <= state_d;
      sw_en_o    <= sw_en_d;
      sw_clr_o   <= sw_clr_d;
      win_o      <= win_d;
      lose_o     <= lose_d;
      score_o    <= score_d;
      attempts_o <= att_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_game_ctrl.sv
// Scoreboard bench for stopwatch_game_ctrl: the driver pushes the expected
// output bundle for every clock edge, a monitor pops and compares after it.
module tb_stopwatch_game_ctrl;

  localparam int TOL   = 2;
  localparam int SMAX  = 9;
  localparam int TICKS = 10;

  logic       clk_i = 1'b0;
  logic       res_ni = 1'b0;
  logic       btn_go_i = 1'b0;
  logic       btn_clr_i = 1'b0;
  logic [6:0] val_x10ms_i = '0;
  logic       sw_en_o, sw_clr_o, win_o, lose_o;
  logic [3:0] score_o;
  logic [6:0] attempts_o;

  stopwatch_game_ctrl #(.WIN_TOL(TOL), .SCORE_MAX(SMAX), .RESULT_TICKS(TICKS)) dut (
    .clk_i(clk_i), .res_ni(res_ni), .btn_go_i(btn_go_i), .btn_clr_i(btn_clr_i),
    .val_x10ms_i(val_x10ms_i), .sw_en_o(sw_en_o), .sw_clr_o(sw_clr_o),
    .win_o(win_o), .lose_o(lose_o), .score_o(score_o), .attempts_o(attempts_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       en, clr, win, lose;
    logic [3:0] score;
    logic [6:0] att;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference game: where the player is in the round, plus tallies.
  bit running, stopped, showing;
  int shown_for, m_score, m_att;
  bit m_en, m_clr, m_win, m_lose;

  `ifdef STOPWATCH_GAME_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
  `else
  localparam bit AUTOCLR = 1'b0;
  `endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    running = 0; stopped = 0; showing = 0; shown_for = 0;
    m_score = 0; m_att = 0; m_en = 0; m_clr = 0; m_win = 0; m_lose = 0;
  endfunction

  function automatic bool_win(input int v);
    if (v > 99) return 1'b0;
    return (v <= TOL) || (v >= 100 - TOL);
  endfunction

  // Advance the reference game by one clock edge.
  function automatic void model_edge(input bit go, input bit clr, input int v);
    m_clr = 0;
    if (clr) begin
      model_reset();
      m_clr = 1;
    end else if (stopped) begin
      stopped = 0; showing = 1; shown_for = 0;
      m_win = bool_win(v); m_lose = !m_win;
      m_att = (m_att >= 127) ? 127 : m_att + 1;
      if (m_win) m_score = (m_score >= SMAX) ? SMAX : m_score + 1;
    end else if (showing) begin
      shown_for++;
      if (go || (AUTOCLR && shown_for >= TICKS)) begin
        showing = 0; m_clr = 1; m_win = 0; m_lose = 0;
      end
    end else if (running) begin
      if (go) begin running = 0; stopped = 1; m_en = 0; end
    end else if (go) begin
      running = 1; m_en = 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.en = m_en; e.clr = m_clr; e.win = m_win; e.lose = m_lose;
    e.score = 4'(m_score); e.att = 7'(m_att);
    return e;
  endfunction

  // One cycle of stimulus; returns just after the edge with outputs settled.
  task automatic step(input bit go, input bit clr, input int v, input bit rst_drop = 1'b0);
    @(negedge clk_i);
    btn_go_i = go; btn_clr_i = clr; val_x10ms_i = 7'(v);
    if (rst_drop) begin
      res_ni = 1'b0;
      #1;
      chk("async_reset", {sw_en_o, sw_clr_o, win_o, lose_o, score_o, attempts_o}, 0);
      model_reset();
    end else begin
      res_ni = 1'b1;
      model_edge(go, clr, v);
    end
    q.push_back(model_out());
    @(posedge clk_i);
    #1;
  endtask

  // Full round ending in RESULT, then leave it with a go press.
  task automatic play(input int v, input bit exp_win);
    step(1, 0, v);
    step(1, 0, v);
    step(0, 0, v);
    chk("round_win", win_o, exp_win);
    chk("round_lose", lose_o, !exp_win);
    step(1, 0, v);
    chk("next_clr", sw_clr_o, 1);
  endtask

  // Monitor: compare every edge that has an expectation queued.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {sw_en_o, sw_clr_o, win_o, lose_o, score_o, attempts_o};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_outputs: got en=%b clr=%b win=%b lose=%b score=%0d att=%0d expected en=%b clr=%b win=%b lose=%b score=%0d att=%0d (t=%0t)",
                   a.en, a.clr, a.win, a.lose, a.score, a.att,
                   e.en, e.clr, e.win, e.lose, e.score, e.att, $time);
        end
      end
    end
  end

  initial begin
    int vals[4] = '{2, 3, 97, 98};
    bit exps[4] = '{1, 0, 0, 1};
    int pool[8] = '{0, 1, 2, 3, 50, 97, 98, 99};
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_state", {sw_en_o, sw_clr_o, win_o, lose_o, score_o, attempts_o}, 0);

    // Start from IDLE: enable next cycle, no clear pulse.
    step(1, 0, 0);
    chk("start_en", sw_en_o, 1);
    chk("start_noclr", sw_clr_o, 0);
    // Stop at 00: freeze after one cycle, win after two.
    step(1, 0, 0);
    chk("stop_en", sw_en_o, 0);
    step(0, 0, 0);
    chk("win_at_00", win_o, 1);
    chk("score_first", score_o, 1);
    chk("att_first", attempts_o, 1);
    step(1, 0, 0);
    chk("exit_clr", sw_clr_o, 1);

    // Tolerance boundaries.
    step(0, 1, 0);
    foreach (vals[i]) play(vals[i], exps[i]);
    chk("tol_score", score_o, 2);
    chk("tol_att", attempts_o, 4);

    // Score saturation.
    step(0, 1, 0);
    repeat (9) play(0, 1);
    play(0, 1);
    chk("sat_score", score_o, 9);
    chk("sat_att", attempts_o, 10);
    play(100, 0);

    // Clear together with go while running.
    step(1, 0, 0);
    step(1, 1, 0);
    chk("clr_pulse", sw_clr_o, 1);
    chk("clr_score", score_o, 0);
    chk("clr_att", attempts_o, 0);
    chk("clr_en", sw_en_o, 0);
    step(0, 0, 0);
    chk("clr_noresult", win_o | lose_o, 0);

    // Hold RESULT with no press.
    step(1, 0, 0);
    step(1, 0, 50);
    step(0, 0, 50);
    chk("hold_lose", lose_o, 1);
    if (AUTOCLR) begin
      repeat (TICKS - 1) step(0, 0, 50);
      chk("auto_early", sw_clr_o, 0);
      step(0, 0, 50);
      chk("auto_clr", sw_clr_o, 1);
    end else begin
      repeat (1000) step(0, 0, 50);
      chk("hold_result", lose_o, 1);
      step(1, 0, 0);
    end

    // Reset while running.
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 0, 0, 1'b1);
    step(0, 0, 0);
    chk("post_rst_en", sw_en_o, 0);
    step(1, 0, 0);
    chk("post_rst_idle", sw_en_o, 1);

    // Random play.
    for (int n = 0; n < 3000; n++) begin
      bit go, clr, rd;
      int v;
      go  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 40) == 0);
      rd  = ($urandom_range(0, 400) == 0);
      v   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : pool[$urandom_range(0, 7)];
      step(go, clr, v, rd);
    end

    step(0, 0, 0);
    repeat (2) @(posedge clk_i);
    #2;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
